fpga_input_console: RTL and testbench
=====================================

Name: fpga_input_console

Overview:
- Board-side input front end for the 16-bit CPU on the DE2-115. It is the input-direction counterpart of the HEX/LED display path.
- Debounces the raw active-low pushbuttons and generates the CPU step-enable, either as single steps or as free-run ticks.
- Latches the slide-switch word into a data register and presents it to the CPU with a valid/ack handshake.
- Sits between the board pins and cpu_16bit, and replaces the direct KEY-as-clock and SW-as-input wiring.

Parameters:
- DEBOUNCE_CYCLES, 1000000: number of consecutive cycles a synchronized key must differ from its debounced state before it is accepted (20 ms at 50 MHz).
- CNT_W, 20: width of each debounce counter. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- RUN_DIV, 25000000: period, in clk cycles, of step_en pulses in RUN mode.
- DIV_W, 25: width of the run divider. Must satisfy 2^DIV_W >= RUN_DIV.

Ports:
- clk  in  1  system clock (50 MHz board clock)
- rst  in  1  asynchronous, active-high reset
- key_step_n  in  1  raw step pushbutton; 0 = pressed
- key_mode_n  in  1  raw mode-toggle pushbutton; 0 = pressed
- key_load_n  in  1  raw load pushbutton; 0 = pressed
- sw  in  16  raw slide switches; treated as quasi-static and not synchronized
- data_ack  in  1  CPU consumed data_out; one-cycle pulse
- step_en  out  1  one-cycle CPU step enable
- run_mode  out  1  1 = RUN, 0 = STEP
- data_out  out  16  latched switch word
- data_valid  out  1  data_out holds an unconsumed word
- key_state  out  3  debounced pressed flags {load, mode, step}; 1 = pressed

Behaviour:
- Reset (asynchronous, active-high), applied in every state including mid-debounce and mid-handshake:
  - sync flops and debounced registers go to 1 (released); key_state = 0.
  - All debounce counters and the run divider go to 0.
  - step_en = 0, run_mode = 0 (STEP), data_out = 0, data_valid = 0.
- Per key, identical logic:
  - 2-flop synchronizer; sync = output of the second flop.
  - If sync == deb: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: deb <= sync and counter <= 0.
  - Else: counter <= counter+1.
  - Any bounce back to the deb value restarts the count from 0.
- Press event: a registered one-cycle pulse on the deb 1->0 transition. No event on release.
- Press timing: if a key is sampled low at edge 0 and stays low, deb falls at edge DEBOUNCE_CYCLES+1 and the press pulse is high for the cycle after edge DEBOUNCE_CYCLES+2.
- key_state = ~deb.
- Mode FSM, states STEP and RUN:
  - Mode press toggles the state.
  - Entering RUN clears the divider.
  - Leaving RUN forces step_en = 0 on the following cycle.
- STEP state: a step press produces step_en = 1 for exactly one cycle, registered one cycle after the press pulse.
- RUN state:
  - Divider counts 0..RUN_DIV-1 and wraps.
  - step_en = 1 for the single cycle after the divider reaches RUN_DIV-1.
  - Step presses are ignored.
- Mode press and step press in the same cycle: the mode toggle takes effect, and the step is honoured only if the FSM was in STEP before the toggle.
- Load handshake:
  - A load press sets data_out <= sw and data_valid <= 1 on the next edge.
  - data_ack while data_valid = 1 clears data_valid on the next edge. data_out holds its value.
  - data_ack while data_valid = 0 is ignored.
  - Load press while data_valid = 1 overwrites data_out and data_valid stays 1.
  - Load press and data_ack in the same cycle: the load wins (new data, data_valid = 1).
- Holding a key generates exactly one event. Another event requires release debounce followed by press debounce.

Test Plan:
- DEBOUNCE_CYCLES=4. Assert rst mid-count with key_step_n low. Required: all outputs 0, key_state=000, and a fresh 4-cycle debounce after rst drops (deb falls at edge 5, step_en high after edge 7).
- DEBOUNCE_CYCLES=4. key_step_n low for 3 cycles, high 1 cycle, low 10 cycles. Required: the first burst gives no event; exactly one step_en pulse from the second burst, timed from its start; no further pulse while held.
- RUN_DIV=5. Press mode. Required: run_mode=1 and step_en every 5 cycles. A step press in RUN gives no extra pulse. A second mode press gives run_mode=0 and step_en stays 0.
- sw=16'hBEEF, press load. Required: data_out=16'hBEEF, data_valid=1. data_ack pulse -> data_valid=0 next cycle, data_out unchanged.
- data_valid=1 with 16'hBEEF, sw=16'h1234. Load press and data_ack land in the same cycle. Required: data_out=16'h1234, data_valid stays 1.
- data_ack pulse while data_valid=0. Required: no change to any output.

Source files
------------

// File: rtl/fpga_input_console.sv
// Board input front end: debounced keys drive the CPU step enable (single step or free run) and latch the switch word.
// Key press to step_en/data_valid is DEBOUNCE_CYCLES+3 edges from first sample; data_valid holds until data_ack, and a new load overwrites.
module fpga_input_console #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int RUN_DIV         = 25000000,
    parameter int DIV_W           = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_step_n,
    input  logic        key_mode_n,
    input  logic        key_load_n,
    input  logic [15:0] sw,
    input  logic        data_ack,
    output logic        step_en,
    output logic        run_mode,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [2:0]  key_state
);

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    logic [2:0]            key_raw;
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            deb_q, deb_d;
    logic [2:0]            deb_prev_q;
    logic [2:0]            press_q, press_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    mode_t                 mode_q, mode_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  step_en_q, step_en_d;
    logic [15:0]           data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;

    logic                  step_press, mode_press, load_press;

    // Bit order {load, mode, step} matches key_state.
    assign key_raw = {key_load_n, key_mode_n, key_step_n};

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // Pulse one cycle after deb falls; release produces nothing.
        press_d = deb_prev_q & ~deb_q;
    end

    assign step_press = press_q[0];
    assign mode_press = press_q[1];
    assign load_press = press_q[2];

    always_comb begin
        mode_d    = mode_q;
        div_d     = div_q;
        step_en_d = 1'b0;
        case (mode_q)
            MODE_STEP: begin
                step_en_d = step_press;
                if (mode_press) begin
                    mode_d = MODE_RUN;
                    div_d  = '0;
                end
            end
            MODE_RUN: begin
                if (div_q == DIV_W'(RUN_DIV - 1)) begin
                    div_d     = '0;
                    step_en_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                if (mode_press) begin
                    mode_d    = MODE_STEP;
                    step_en_d = 1'b0;
                end
            end
        endcase
    end

    // A load in the same cycle as an ack wins: the new word is still unconsumed.
    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        if (load_press) begin
            data_out_d   = sw;
            data_valid_d = 1'b1;
        end else if (data_ack) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            deb_q        <= '1;
            deb_prev_q   <= '1;
            press_q      <= '0;
            cnt_q        <= '0;
            mode_q       <= MODE_STEP;
            div_q        <= '0;
            step_en_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            sync1_q      <= key_raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_q;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            div_q        <= div_d;
            step_en_q    <= step_en_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign step_en    = step_en_q;
    assign run_mode   = (mode_q == MODE_RUN);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign key_state  = ~deb_q;

endmodule

// File: tb/tb_fpga_input_console.sv
// Bench for fpga_input_console with short debounce and run periods; step pulses and data changes are scored against queues.
module tb_fpga_input_console;

    localparam int DC = 4;
    localparam int CW = 3;
    localparam int RD = 5;
    localparam int DW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_step_n, key_mode_n, key_load_n;
    logic [15:0] sw;
    logic        data_ack;
    logic        step_en, run_mode, data_valid;
    logic [15:0] data_out;
    logic [2:0]  key_state;

    fpga_input_console #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CW),
        .RUN_DIV        (RD),
        .DIV_W          (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_step_n(key_step_n),
        .key_mode_n(key_mode_n),
        .key_load_n(key_load_n),
        .sw        (sw),
        .data_ack  (data_ack),
        .step_en   (step_en),
        .run_mode  (run_mode),
        .data_out  (data_out),
        .data_valid(data_valid),
        .key_state (key_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          cyc;
        logic [15:0] dat;
        logic        vld;
    } dexp_t;

    int          step_q[$];
    dexp_t       data_q[$];
    logic [15:0] prev_out = 16'h0;
    logic        prev_vld = 1'b0;
    int          exp_cyc;
    dexp_t       exp_d;

    // Step pulses and data/valid changes are popped against their expected cycle.
    always @(negedge clk) begin
        if (step_en === 1'b1) begin
            vectors++;
            if (step_q.size() == 0) begin
                miscompares++;
                $display("FAIL step_pulse: step_en high at cycle %0d, none required", cyc);
            end else begin
                exp_cyc = step_q.pop_front();
                if (exp_cyc != cyc) begin
                    miscompares++;
                    $display("FAIL step_pulse: step_en high at cycle %0d, required at cycle %0d", cyc, exp_cyc);
                end
            end
        end
        if (data_out !== prev_out || data_valid !== prev_vld) begin
            vectors++;
            if (data_q.size() == 0) begin
                miscompares++;
                $display("FAIL data_change: cycle %0d data_out=%h valid=%b, no change required", cyc, data_out, data_valid);
            end else begin
                exp_d = data_q.pop_front();
                if (exp_d.cyc != cyc || exp_d.dat !== data_out || exp_d.vld !== data_valid) begin
                    miscompares++;
                    $display("FAIL data_change: cycle %0d data_out=%h valid=%b, required cycle %0d data_out=%h valid=%b",
                             cyc, data_out, data_valid, exp_d.cyc, exp_d.dat, exp_d.vld);
                end
            end
        end
        prev_out = data_out;
        prev_vld = data_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int r;
        rst = 1'b1;
        tick(3);
        vectors++;
        if ({step_en, run_mode, data_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl: {step_en,run_mode,data_valid}=%b, required 000", {step_en, run_mode, data_valid});
        end
        vectors++;
        if (data_out !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data: data_out=%h, required 0000", data_out);
        end
        vectors++;
        if (key_state !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_keys: key_state=%b, required 000", key_state);
        end
        rst = 1'b0;
        tick(2);
        key_step_n = 1'b0;
        tick(3);
        rst = 1'b1;
        #1;
        vectors++;
        if ({key_state, step_en, run_mode, data_valid} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_midcount: key_state=%b step_en=%b run_mode=%b valid=%b, required all 0",
                     key_state, step_en, run_mode, data_valid);
        end
        tick(2);
        rst = 1'b0;
        r = cyc;
        step_q.push_back(r + 8);
        tick(5);
        vectors++;
        if (key_state !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_redebounce_early: key_state=%b, required 000", key_state);
        end
        tick(1);
        vectors++;
        if (key_state !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_redebounce: key_state=%b, required 001", key_state);
        end
        tick(6);
        vectors++;
        if (step_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_step_pending: %0d step pulses missing, required 0", step_q.size());
            step_q.delete();
        end
        key_step_n = 1'b1;
        tick(10);
    endtask

    task automatic test_glitch();
        int n;
        n = cyc;
        key_step_n = 1'b0;
        step_q.push_back(n + 12);
        tick(3);
        key_step_n = 1'b1;
        tick(1);
        key_step_n = 1'b0;
        tick(5);
        vectors++;
        if (key_state !== 3'b000) begin
            miscompares++;
            $display("FAIL glitch_restart: key_state=%b, required 000", key_state);
        end
        tick(4);
        vectors++;
        if (key_state !== 3'b001) begin
            miscompares++;
            $display("FAIL glitch_held: key_state=%b, required 001", key_state);
        end
        tick(1);
        key_step_n = 1'b1;
        tick(10);
        vectors++;
        if (step_q.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_step_pending: %0d step pulses missing, required 0", step_q.size());
            step_q.delete();
        end
    endtask

    task automatic test_run_mode();
        int n;
        n = cyc;
        key_mode_n = 1'b0;
        for (int k = 0; k < 5; k++) step_q.push_back(n + 13 + 5 * k);
        tick(7);
        vectors++;
        if (run_mode !== 1'b0) begin
            miscompares++;
            $display("FAIL run_enter_early: run_mode=%b, required 0", run_mode);
        end
        tick(1);
        vectors++;
        if (run_mode !== 1'b1) begin
            miscompares++;
            $display("FAIL run_enter: run_mode=%b, required 1", run_mode);
        end
        key_mode_n = 1'b1;
        tick(3);
        key_step_n = 1'b0;
        tick(10);
        key_step_n = 1'b1;
        tick(9);
        key_mode_n = 1'b0;
        tick(7);
        vectors++;
        if (run_mode !== 1'b1) begin
            miscompares++;
            $display("FAIL run_leave_early: run_mode=%b, required 1", run_mode);
        end
        tick(1);
        vectors++;
        if ({run_mode, step_en} !== 2'b00) begin
            miscompares++;
            $display("FAIL run_leave: {run_mode,step_en}=%b, required 00", {run_mode, step_en});
        end
        tick(2);
        key_mode_n = 1'b1;
        tick(15);
        vectors++;
        if (step_q.size() != 0 || run_mode !== 1'b0) begin
            miscompares++;
            $display("FAIL run_pending: %0d step pulses missing, run_mode=%b, required 0 and 0", step_q.size(), run_mode);
            step_q.delete();
        end
    endtask

    task automatic test_load();
        int n;
        n = cyc;
        sw = 16'hBEEF;
        key_load_n = 1'b0;
        data_q.push_back('{cyc: n + 8, dat: 16'hBEEF, vld: 1'b1});
        tick(7);
        vectors++;
        if (data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_early: data_valid=%b, required 0", data_valid);
        end
        tick(1);
        key_load_n = 1'b1;
        tick(10);
        n = cyc;
        data_ack = 1'b1;
        data_q.push_back('{cyc: n + 1, dat: 16'hBEEF, vld: 1'b0});
        tick(1);
        data_ack = 1'b0;
        tick(1);
        vectors++;
        if (data_out !== 16'hBEEF || data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_hold: data_out=%h valid=%b, required BEEF 0", data_out, data_valid);
        end
        tick(5);
    endtask

    task automatic test_back_to_back();
        int n;
        n = cyc;
        key_load_n = 1'b0;
        data_q.push_back('{cyc: n + 8, dat: 16'hBEEF, vld: 1'b1});
        tick(8);
        key_load_n = 1'b1;
        tick(10);
        n = cyc;
        sw = 16'h1234;
        key_load_n = 1'b0;
        data_q.push_back('{cyc: n + 8, dat: 16'h1234, vld: 1'b1});
        tick(7);
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        key_load_n = 1'b1;
        vectors++;
        if (data_out !== 16'h1234 || data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL load_vs_ack: data_out=%h valid=%b, required 1234 1", data_out, data_valid);
        end
        tick(10);
    endtask

    task automatic test_idle_ack();
        int n;
        n = cyc;
        data_ack = 1'b1;
        data_q.push_back('{cyc: n + 1, dat: 16'h1234, vld: 1'b0});
        tick(1);
        data_ack = 1'b0;
        tick(3);
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        tick(4);
        vectors++;
        if (data_out !== 16'h1234 || {data_valid, step_en, run_mode} !== 3'b000 || key_state !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_ack: data_out=%h valid=%b step_en=%b run_mode=%b key_state=%b, required 1234 0 0 0 000",
                     data_out, data_valid, step_en, run_mode, key_state);
        end
        vectors++;
        if (data_q.size() != 0) begin
            miscompares++;
            $display("FAIL data_pending: %0d data changes missing, required 0", data_q.size());
            data_q.delete();
        end
    endtask

    initial begin
        rst        = 1'b1;
        key_step_n = 1'b1;
        key_mode_n = 1'b1;
        key_load_n = 1'b1;
        sw         = 16'h0;
        data_ack   = 1'b0;
        test_reset();
        test_glitch();
        test_run_mode();
        test_load();
        test_back_to_back();
        test_idle_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
